// File: rtl/branch_resolver.sv
// Branch resolver: in-order FIFO of branch predictions, resolved oldest-first against a compare.
// Optional macro BRANCH_RESOLVER_STATS_EN adds saturating resolution/mispredict counters.
module branch_resolver (
    input  logic        clk,
    input  logic        rst_h,
    input  logic        pred_valid,
    input  logic        pred_bit,
    output logic        pred_ready,
    input  logic        res_valid,
    input  logic [2:0]  res_op,
    input  logic [31:0] res_a,
    input  logic [31:0] res_b,
    input  logic        flush,
    output logic        act_taken,
    output logic        pred_taken,
    output logic [1:0]  branch_cond,
    output logic        mispredict,
    output logic        res_err
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [15:0] stat_resolved,
    output logic [15:0] stat_mispred
`endif
);

    logic [3:0] fifo_q;
    logic [3:0] fifo_d;
    logic [2:0] count_q, count_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic       act_taken_q, act_taken_d;
    logic       pred_taken_q, pred_taken_d;
    logic [1:0] branch_cond_q, branch_cond_d;
    logic       mispredict_q, mispredict_d;
    logic       res_err_q, res_err_d;

    logic       taken_c;
    logic       head_c;
    logic       push_c;
    logic       fire_c;
    logic       miss_c;
    logic       wr_en_c;

    // Unassigned compare codes (010, 011) resolve as not-taken.
    always_comb begin
        taken_c = 1'b0;
        case (res_op)
            3'b000:  taken_c = (res_a == res_b);
            3'b001:  taken_c = (res_a != res_b);
            3'b100:  taken_c = ($signed(res_a) <  $signed(res_b));
            3'b101:  taken_c = ($signed(res_a) >= $signed(res_b));
            3'b110:  taken_c = (res_a <  res_b);
            3'b111:  taken_c = (res_a >= res_b);
            default: taken_c = 1'b0;
        endcase
    end

    assign pred_ready = (count_q < 3'd4);
    assign head_c     = fifo_q[rd_ptr_q];
    assign push_c     = pred_valid && pred_ready;
    assign fire_c     = res_valid && !flush && (count_q != 3'd0);
    assign miss_c     = fire_c && (taken_c != head_c);
    assign wr_en_c    = push_c && !flush && !miss_c;

    // Only the slot under the write pointer captures pred_bit, and only on a surviving push.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_entry
            always_comb begin
                fifo_d[gi] = fifo_q[gi];
                if (wr_en_c && (wr_ptr_q == gi[1:0])) begin
                    fifo_d[gi] = pred_bit;
                end
            end
        end
    endgenerate

    always_comb begin
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        act_taken_d   = act_taken_q;
        pred_taken_d  = pred_taken_q;
        branch_cond_d = 2'b00;
        mispredict_d  = 1'b0;
        res_err_d     = res_err_q;

        if (res_valid && (count_q == 3'd0)) begin
            res_err_d = 1'b1;
        end

        if (fire_c) begin
            act_taken_d   = taken_c;
            pred_taken_d  = head_c;
            branch_cond_d = 2'b01;
            mispredict_d  = miss_c;
        end

        if (flush || miss_c) begin
            count_d  = 3'd0;
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
        end else begin
            if (fire_c) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            if (wr_en_c) begin
                wr_ptr_d = wr_ptr_q + 2'd1;
            end
            if (fire_c && !wr_en_c) begin
                count_d = count_q - 3'd1;
            end else if (wr_en_c && !fire_c) begin
                count_d = count_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_h) begin
            fifo_q        <= 4'b0000;
            count_q       <= 3'd0;
            rd_ptr_q      <= 2'd0;
            wr_ptr_q      <= 2'd0;
            act_taken_q   <= 1'b0;
            pred_taken_q  <= 1'b0;
            branch_cond_q <= 2'b00;
            mispredict_q  <= 1'b0;
            res_err_q     <= 1'b0;
        end else begin
            fifo_q        <= fifo_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            act_taken_q   <= act_taken_d;
            pred_taken_q  <= pred_taken_d;
            branch_cond_q <= branch_cond_d;
            mispredict_q  <= mispredict_d;
            res_err_q     <= res_err_d;
        end
    end

    assign act_taken   = act_taken_q;
    assign pred_taken  = pred_taken_q;
    assign branch_cond = branch_cond_q;
    assign mispredict  = mispredict_q;
    assign res_err     = res_err_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] stat_resolved_q, stat_resolved_d;
    logic [15:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_resolved_d = stat_resolved_q;
        stat_mispred_d  = stat_mispred_q;
        if (fire_c && (stat_resolved_q != 16'hFFFF)) begin
            stat_resolved_d = stat_resolved_q + 16'd1;
        end
        if (miss_c && (stat_mispred_q != 16'hFFFF)) begin
            stat_mispred_d = stat_mispred_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_h) begin
            stat_resolved_q <= 16'd0;
            stat_mispred_q  <= 16'd0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized bench for branch_resolver: a queue-based reference model feeds a scoreboard
// of expected resolutions; a monitor checks every pulse plus the held/level outputs each cycle.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_h = 1'b1;
    logic        pred_valid = 1'b0;
    logic        pred_bit = 1'b0;
    logic        pred_ready;
    logic        res_valid = 1'b0;
    logic [2:0]  res_op = 3'b000;
    logic [31:0] res_a = 32'd0;
    logic [31:0] res_b = 32'd0;
    logic        flush = 1'b0;
    logic        act_taken;
    logic        pred_taken;
    logic [1:0]  branch_cond;
    logic        mispredict;
    logic        res_err;

    branch_resolver dut (
        .clk         (clk),
        .rst_h       (rst_h),
        .pred_valid  (pred_valid),
        .pred_bit    (pred_bit),
        .pred_ready  (pred_ready),
        .res_valid   (res_valid),
        .res_op      (res_op),
        .res_a       (res_a),
        .res_b       (res_b),
        .flush       (flush),
        .act_taken   (act_taken),
        .pred_taken  (pred_taken),
        .branch_cond (branch_cond),
        .mispredict  (mispredict),
        .res_err     (res_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic act;
        logic pred;
        logic mis;
    } res_rec_t;

    res_rec_t exp_q[$];     // expected resolution pulses, oldest first
    logic     model_q[$];   // in-flight predictions, oldest first

    // Expected level outputs after the most recent edge (reset state to begin with)
    logic exp_act   = 1'b0;
    logic exp_pred  = 1'b0;
    logic exp_err   = 1'b0;
    logic exp_ready = 1'b1;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    bit done  = 1'b0;

    function automatic void chk(string name, logic [31:0] actual, logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, required, $time);
        end
    endfunction

    function automatic logic ref_taken(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return ua < ub;
            3'b111:  return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // One clock cycle: drive inputs at the negedge and advance the model to the following edge.
    task automatic cyc(input logic rst, input logic pv, input logic pb, input logic rv,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
        logic     t;
        logic     h;
        bit       push_ok;
        res_rec_t r;
        @(negedge clk);
        rst_h = rst; pred_valid = pv; pred_bit = pb; res_valid = rv;
        res_op = op; res_a = a; res_b = b; flush = fl;
        $display("cyc t=%0t rst=%0b pv=%0b pb=%0b rv=%0b op=%03b a=%08h b=%08h fl=%0b occ=%0d",
                 $time, rst, pv, pb, rv, op, a, b, fl, model_q.size());
        if (rst) begin
            model_q.delete();
            exp_act = 1'b0; exp_pred = 1'b0; exp_err = 1'b0;
        end else begin
            push_ok = pv && (model_q.size() < 4);
            if (rv && model_q.size() == 0) exp_err = 1'b1;
            if (fl) begin
                model_q.delete();
            end else if (rv && model_q.size() > 0) begin
                h = model_q[0];
                t = ref_taken(op, a, b);
                r.act = t; r.pred = h; r.mis = (t != h);
                exp_q.push_back(r);
                exp_act = t; exp_pred = h;
                if (t != h) begin
                    model_q.delete();
                end else begin
                    void'(model_q.pop_front());
                    if (push_ok) model_q.push_back(pb);
                end
            end else if (push_ok) begin
                model_q.push_back(pb);
            end
        end
        exp_ready = (model_q.size() < 4);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic push(input logic pb);
        cyc(1'b0, 1'b1, pb, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    endtask

    // Monitor: sample 2 time units after each rising edge.
    initial begin
        res_rec_t r;
        while (!done) begin
            @(posedge clk);
            #2;
            chk("pred_ready", pred_ready, exp_ready);
            chk("res_err", res_err, exp_err);
            chk("act_taken", act_taken, exp_act);
            chk("pred_taken", pred_taken, exp_pred);
            if (branch_cond == 2'b01) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("pulse_act", act_taken, r.act);
                    chk("pulse_pred", pred_taken, r.pred);
                    chk("pulse_mis", mispredict, r.mis);
                end
            end else begin
                chk("branch_cond_idle", branch_cond, 2'b00);
                chk("mispredict_idle", mispredict, 1'b0);
                chk("missing_pulse", exp_q.size(), 0);
            end
        end
    end

    initial begin
        logic [2:0]  ops [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [31:0] a, b;
        reset();
        reset();
        // Single correct EQ resolution
        push(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'd5, 32'd5, 1'b0);
        idle();
        // Fill, overflow push, then one correct resolution with a concurrent push
        for (int i = 0; i < 5; i++) push(1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'd7, 32'd7, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'd7, 32'd7, 1'b0);
        idle();
        // Signed-less-than mispredict drops the same-cycle push
        reset();
        for (int i = 0; i < 3; i++) push(1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0);
        idle();
        // Resolution on empty FIFO sets the sticky error
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 32'd1, 32'd2, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        reset();
        // Flush outranks a concurrent push and resolution
        push(1'b1);
        push(1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 32'd3, 32'd3, 1'b1);
        idle();
        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            a = $urandom();
            case ($urandom_range(3))
                0: b = a;
                1: b = $urandom();
                2: b = a ^ 32'h8000_0000;
                default: b = a + 32'd1;
            endcase
            cyc(($urandom_range(299) == 0), ($urandom_range(1) == 0), $urandom_range(1),
                ($urandom_range(9) < 4), ops[$urandom_range(5)], a, b,
                ($urandom_range(39) == 0));
        end
        idle();
        idle();
        done = 1'b1;
        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("pulses_seen", (pulses > 50), 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; every state element updates on its rising edge.
REQ-002 SHALL have port rst_h, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port pred_valid, input, 1: fetch pushes one conditional-branch prediction.
REQ-004 SHALL have port pred_bit, input, 1: predicted direction, 1 = taken.
REQ-005 SHALL have port pred_ready, output, 1: high when occupancy is below 4; a push completes only when pred_valid and pred_ready are both high.
REQ-006 SHALL have port res_valid, input, 1: execute resolves the oldest in-flight branch.
REQ-007 SHALL have port res_op, input, 3: compare code; 000 = EQ, 001 = NE, 100 = LT signed, 101 = GE signed, 110 = LTU, 111 = GEU.
REQ-008 SHALL have ports res_a and res_b, input, 32 each: compare operands.
REQ-009 SHALL have port flush, input, 1: pipeline flush from elsewhere.
REQ-010 SHALL have port act_taken, output, 1: registered actual direction.
REQ-011 SHALL have port pred_taken, output, 1: registered predicted direction of the resolved branch.
REQ-012 SHALL have port branch_cond, output, 2: 2'b01 for exactly one cycle per resolution, else 2'b00.
REQ-013 SHALL have port mispredict, output, 1: one-cycle pulse when act_taken differs from pred_taken.
REQ-014 SHALL have port res_err, output, 1: sticky flag for a resolution attempted while the FIFO is empty.

Function
REQ-015 SHALL hold predictions in a 4-entry in-order FIFO with a 3-bit occupancy count and 2-bit wrapping read/write pointers.
REQ-016 SHALL pop the head entry on a resolution when res_valid is high, flush is low and occupancy is nonzero.
REQ-017 SHALL evaluate the compare combinationally and register act_taken, pred_taken (head entry), branch_cond = 2'b01 and mispredict on the same edge as the pop; latency from res_valid to outputs is 1 cycle.
REQ-018 SHALL hold act_taken and pred_taken at their last values, and drive branch_cond and mispredict to 0, in any cycle with no resolution.
REQ-019 SHALL derive pred_ready from occupancy only; a pop in the same cycle does not raise it.
REQ-020 SHALL, on a resolution without mispredict combined with a push, pop and push together so occupancy is unchanged.
REQ-021 SHALL, on a mispredicting resolution, clear occupancy and both pointers at that edge and discard any same-cycle push.
REQ-022 SHALL, on flush, clear occupancy and both pointers; flush outranks push and resolution, and no branch_cond pulse is produced that cycle.
REQ-023 SHALL ignore res_valid while the FIFO is empty, set res_err and produce no pulse.
REQ-024 SHALL keep res_err set until reset.
REQ-025 SHALL ignore the value of pred_bit when no push completes.

Reset
REQ-026 SHALL, with rst_h high at a rising edge, clear occupancy, pointers, act_taken, pred_taken, branch_cond, mispredict and res_err to 0; pred_ready reads 1 afterwards.
REQ-027 SHALL let reset override every other input in the same cycle, including in-flight entries and pending resolutions.

Configuration
REQ-028 SHALL, when BRANCH_RESOLVER_STATS_EN is defined, add 16-bit outputs stat_resolved and stat_mispred, reset to 0, incremented per resolution and per mispredict, saturating at 16'hFFFF.
REQ-029 SHALL, without BRANCH_RESOLVER_STATS_EN, omit the counters and those ports, with all other behaviour identical.

Verification
REQ-030 Push pred_bit = 1; resolve with res_op = 000, a = b = 5 -> next cycle act_taken = 1, pred_taken = 1, branch_cond = 01, mispredict = 0.
REQ-031 Push 4 entries -> pred_ready = 0; 5th push is ignored; one correct resolution -> occupancy 3, pred_ready = 1 next cycle.
REQ-032 Push pred_bit = 0 ×3; resolve BLT with a = 32'hFFFFFFFF, b = 1 -> act_taken = 1, mispredict = 1, occupancy 0; same-cycle push is dropped.
REQ-033 res_valid on empty FIFO -> res_err = 1, branch_cond = 00; res_err stays 1 until rst_h.
REQ-034 flush together with res_valid and pred_valid on 2 entries -> occupancy 0, no pulse, pred_ready = 1.
REQ-035 With BRANCH_RESOLVER_STATS_EN, 65537 mispredicts -> stat_mispred = 16'hFFFF; rst_h mid-run -> all outputs 0.
